// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op codes, state encoding and byte lane constants for the load/store unit
package lsu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;

    // Operation codes; 6 and 7 are reserved and complete as a no-op.
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;

    // Little-endian byte lanes selected by address bit 0.
    localparam logic BYTE_LO = 1'b0;
    localparam logic BYTE_HI = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_STORE    = 3'd2,
        S_RMW_RD   = 3'd3,
        S_RMW_WR   = 3'd4,
        S_FAULT    = 3'd5,
        S_DONE_NOP = 3'd6
    } state_e;

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// rtl/load_store_unit_byte_lane.sv - byte extract with sign/zero extension and byte merge
// Ports:
//   word_in    : source word (memory read data for loads, merge register for RMW)
//   lane       : BYTE_LO selects [7:0], BYTE_HI selects [15:8]
//   sign_ext   : 1 sign-extends the extracted byte, 0 zero-extends it
//   merge_byte : byte inserted into the selected lane
//   ext_data   : extended byte
//   merge_data : word_in with the selected lane replaced by merge_byte
module byte_lane_unit
    import lsu_pkg::*;
(
    input  logic [15:0] word_in,
    input  logic        lane,
    input  logic        sign_ext,
    input  logic [7:0]  merge_byte,
    output logic [15:0] ext_data,
    output logic [15:0] merge_data
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte   = (lane == BYTE_HI) ? word_in[15:8] : word_in[7:0];
        ext_data   = sign_ext ? {{8{sel_byte[7]}}, sel_byte} : {8'h00, sel_byte};
        merge_data = (lane == BYTE_HI) ? {merge_byte, word_in[7:0]}
                                       : {word_in[15:8], merge_byte};
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store controller with byte support and misalignment fault
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   req_valid/req_ready            : request handshake from EX/MEM
//   req_op/addr/wdata/rd           : request fields, latched on accept
//   resp_valid/data/rd/wb/err      : one-cycle registered completion
//   mem_address/data_write/write/read, mem_data_read : data memory interface
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = lsu_pkg::ADDR_W,
    parameter int DATA_W = lsu_pkg::DATA_W,
    parameter int TAG_W  = lsu_pkg::TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_rd,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_rd,
    output logic              resp_wb,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_read
);

    state_e            state, next_state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TAG_W-1:0]  rd_q;
    logic [DATA_W-1:0] merge_q;
    logic              accept;
    logic              write_en;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] lane_ext;
    logic [DATA_W-1:0] lane_merge;

    assign req_ready = (state == S_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    // The lane unit sees memory data for loads and the captured word while merging.
    assign lane_word = (state == S_RMW_WR) ? merge_q : mem_data_read;

    byte_lane_unit u_byte_lane (
        .word_in    (lane_word),
        .lane       (addr_q[0]),
        .sign_ext   (op_q == OP_LB),
        .merge_byte (wdata_q[7:0]),
        .ext_data   (lane_ext),
        .merge_data (lane_merge)
    );

    always_comb begin
        next_state = state;
        mem_read   = 1'b0;
        write_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_LW:          next_state = req_addr[0] ? S_FAULT : S_LOAD;
                        OP_LB, OP_LBU:  next_state = S_LOAD;
                        OP_SW:          next_state = req_addr[0] ? S_FAULT : S_STORE;
                        OP_SB:          next_state = S_RMW_RD;
                        default:        next_state = S_DONE_NOP;
                    endcase
                end
            end
            S_LOAD: begin
                mem_read   = 1'b1;
                next_state = S_IDLE;
            end
            S_STORE: begin
                write_en   = 1'b1;
                next_state = S_IDLE;
            end
            S_RMW_RD: begin
                mem_read   = 1'b1;
                next_state = S_RMW_WR;
            end
            S_RMW_WR: begin
                write_en   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Gating with rst_n keeps an in-flight store from landing on a reset edge.
    assign mem_write      = write_en && rst_n;
    assign mem_address    = (state == S_IDLE) ? '0 : addr_q;
    assign mem_data_write = (state == S_STORE)  ? wdata_q :
                            (state == S_RMW_WR) ? lane_merge : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            merge_q    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_wb    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            state      <= next_state;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_wb    <= 1'b0;
            resp_err   <= 1'b0;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
            end
            case (state)
                S_LOAD: begin
                    resp_valid <= 1'b1;
                    resp_rd    <= rd_q;
                    resp_wb    <= 1'b1;
                    resp_data  <= (op_q == OP_LW) ? mem_data_read : lane_ext;
                end
                S_RMW_RD: merge_q <= mem_data_read;
                S_STORE, S_RMW_WR, S_DONE_NOP: begin
                    resp_valid <= 1'b1;
                    resp_rd    <= rd_q;
                end
                S_FAULT: begin
                    resp_valid <= 1'b1;
                    resp_rd    <= rd_q;
                    resp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
